// File: rtl/risc_toy_hazard_ctrl_if.sv
// Control bundle between the RISC_TOY pipeline and its hazard controller.
// Outputs ending in _c are combinational in the same cycle; haz_cnt is registered.
interface risc_toy_hazard_ctrl_if #(
  parameter int unsigned RAW = 5,
  parameter int unsigned CW  = 16
);
  logic           id_valid;
  logic [RAW-1:0] id_rs1;
  logic [RAW-1:0] id_rs2;
  logic           id_rs1_en;
  logic           id_rs2_en;
  logic [RAW-1:0] id_rd;
  logic           id_we;
  logic           id_load;
  logic           ex_br_taken;
  logic           dmem_wait;

  logic           stall_if_c;
  logic           bubble_ex_c;
  logic           flush_id_c;
  logic           freeze_c;
  logic [1:0]     fwd_a_c;
  logic [1:0]     fwd_b_c;
  logic [CW-1:0]  haz_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_we, id_load,
    output ex_br_taken, dmem_wait,
    input  stall_if_c, bubble_ex_c, flush_id_c, freeze_c, fwd_a_c, fwd_b_c, haz_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_we, id_load,
    input  ex_br_taken, dmem_wait,
    output stall_if_c, bubble_ex_c, flush_id_c, freeze_c, fwd_a_c, fwd_b_c, haz_cnt
  );
endinterface

// File: rtl/risc_toy_hazard_ctrl.sv
// RISC_TOY pipeline hazard controller: RAW detection, stall/bubble/flush/freeze, hazard counter.
// Define RISC_TOY_FWD_EN for load-use-only stalls plus EX operand-forwarding selects.
module risc_toy_hazard_ctrl #(
  parameter int unsigned RAW = 5,
  parameter int unsigned CW  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  risc_toy_hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic           v;
    logic           we;
    logic [RAW-1:0] rd;
  } dst_t;

  dst_t          x_q, m_q, w_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ctl_q, ctl_d;     // {stall_if, bubble_ex, flush_id}
  logic [2:0]    ctl_out_c;
  logic          hz_c, run_c, issue_c;

  function automatic logic hit(dst_t e, logic [RAW-1:0] s, logic en);
    return e.v & e.we & (e.rd == s) & en;
  endfunction

`ifdef RISC_TOY_FWD_EN
  logic           x_ld_q, x_rs1_en_q, x_rs2_en_q;
  logic [RAW-1:0] x_rs1_q, x_rs2_q;

  function automatic logic [1:0] fsel(dst_t m, dst_t w, logic [RAW-1:0] s, logic en);
    if (hit(m, s, en)) return 2'b01;
    if (hit(w, s, en)) return 2'b10;
    return 2'b00;
  endfunction

  // Only a load still in EX cannot be forwarded in time
  assign hz_c = bus.id_valid & x_ld_q &
                (hit(x_q, bus.id_rs1, bus.id_rs1_en) | hit(x_q, bus.id_rs2, bus.id_rs2_en));

  assign bus.fwd_a_c = (rst_n & run_c & x_q.v) ? fsel(m_q, w_q, x_rs1_q, x_rs1_en_q) : 2'b00;
  assign bus.fwd_b_c = (rst_n & run_c & x_q.v) ? fsel(m_q, w_q, x_rs2_q, x_rs2_en_q) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_ld_q     <= 1'b0;
      x_rs1_q    <= '0;
      x_rs2_q    <= '0;
      x_rs1_en_q <= 1'b0;
      x_rs2_en_q <= 1'b0;
    end else if (run_c) begin
      x_ld_q     <= issue_c & bus.id_load;
      x_rs1_q    <= bus.id_rs1;
      x_rs2_q    <= bus.id_rs2;
      x_rs1_en_q <= issue_c & bus.id_rs1_en;
      x_rs2_en_q <= issue_c & bus.id_rs2_en;
    end
  end
`else
  logic unused_id_load;
  assign unused_id_load = bus.id_load;

  // Regfile has no write-to-read bypass, so anything in EX/MEM/WB blocks the reader
  assign hz_c = bus.id_valid &
                (hit(x_q, bus.id_rs1, bus.id_rs1_en) | hit(m_q, bus.id_rs1, bus.id_rs1_en) |
                 hit(w_q, bus.id_rs1, bus.id_rs1_en) | hit(x_q, bus.id_rs2, bus.id_rs2_en) |
                 hit(m_q, bus.id_rs2, bus.id_rs2_en) | hit(w_q, bus.id_rs2, bus.id_rs2_en));

  assign bus.fwd_a_c = 2'b00;
  assign bus.fwd_b_c = 2'b00;
`endif

  // Branch kills the ID instruction, so it overrides the hazard stall
  always_comb begin
    run_c   = ~bus.dmem_wait;
    issue_c = bus.id_valid & ~hz_c & ~bus.ex_br_taken;
    ctl_d   = {~bus.ex_br_taken & hz_c, bus.ex_br_taken | hz_c, bus.ex_br_taken};
    x_d     = issue_c ? {1'b1, bus.id_we, bus.id_rd} : '0;
    cnt_d   = cnt_q;
    if (ctl_d[2] && (cnt_q != '1)) cnt_d = cnt_q + CW'(1);
  end

  // Freeze replays the last unfrozen control word
  assign ctl_out_c       = !rst_n ? 3'b000 : (bus.dmem_wait ? ctl_q : ctl_d);
  assign bus.stall_if_c  = ctl_out_c[2];
  assign bus.bubble_ex_c = ctl_out_c[1];
  assign bus.flush_id_c  = ctl_out_c[0];
  assign bus.freeze_c    = rst_n & bus.dmem_wait;
  assign bus.haz_cnt     = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
      ctl_q <= '0;
    end else if (run_c) begin
      w_q   <= m_q;
      m_q   <= x_q;
      x_q   <= x_d;
      cnt_q <= cnt_d;
      ctl_q <= ctl_d;
    end
  end

endmodule

// File: tb/tb_risc_toy_hazard_ctrl.sv
// Randomized and directed bench for risc_toy_hazard_ctrl against a timeline model of issued ops.
// A second instance with CW=2 shares the stimulus to exercise counter saturation.
module tb_risc_toy_hazard_ctrl;
  localparam int unsigned RAW = 5;
  localparam int unsigned CW  = 16;
`ifdef RISC_TOY_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  typedef struct packed {
    bit v; bit we; bit ld; bit e1; bit e2;
    bit [4:0] rd; bit [4:0] rs1; bit [4:0] rs2;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  risc_toy_hazard_ctrl_if #(.RAW(RAW), .CW(CW)) bus ();
  risc_toy_hazard_ctrl_if #(.RAW(RAW), .CW(2))  bus2 ();

  risc_toy_hazard_ctrl #(.RAW(RAW), .CW(CW)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  risc_toy_hazard_ctrl #(.RAW(RAW), .CW(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  assign bus2.id_valid    = bus.id_valid;
  assign bus2.id_rs1      = bus.id_rs1;
  assign bus2.id_rs2      = bus.id_rs2;
  assign bus2.id_rs1_en   = bus.id_rs1_en;
  assign bus2.id_rs2_en   = bus.id_rs2_en;
  assign bus2.id_rd       = bus.id_rd;
  assign bus2.id_we       = bus.id_we;
  assign bus2.id_load     = bus.id_load;
  assign bus2.ex_br_taken = bus.ex_br_taken;
  assign bus2.dmem_wait   = bus.dmem_wait;

  int n_chk = 0;
  int n_fail = 0;

  // Model: ring[t] is the op that entered EX at unfrozen edge t; age 0 = EX, 1 = MEM, 2 = WB
  op_t         ring [8];
  int unsigned t = 0;
  int          cnt = 0, cnt2 = 0;
  bit [2:0]    held = 3'b000;
  op_t         idle_op = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(op_t e, bit [4:0] s, bit en);
    return e.v && e.we && en && (e.rd == s);
  endfunction

  function automatic op_t at_age(int unsigned a);
    return ring[(t - a) & 7];
  endfunction

  function automatic int fwd_sel(bit [4:0] s, bit en);
    if (writes(at_age(1), s, en)) return 1;
    if (writes(at_age(2), s, en)) return 2;
    return 0;
  endfunction

  function automatic op_t mk(int rd, int rs1, int rs2, bit ld);
    op_t o;
    o = '0;
    o.v = 1'b1; o.we = 1'b1; o.ld = ld; o.e1 = 1'b1; o.e2 = 1'b1;
    o.rd = 5'(rd); o.rs1 = 5'(rs1); o.rs2 = 5'(rs2);
    return o;
  endfunction

  // Drive one cycle, compare every output to the model, then advance the model
  task automatic step(input op_t id, input bit br, input bit dw, input bit rn);
    bit hz;
    bit [2:0] ctl;
    int e_stall, e_bub, e_fl, e_frz, e_fa, e_fb;
    op_t x;
    @(negedge clk);
    rst_n = rn;
    bus.id_valid = id.v; bus.id_rs1 = id.rs1; bus.id_rs2 = id.rs2;
    bus.id_rs1_en = id.e1; bus.id_rs2_en = id.e2; bus.id_rd = id.rd;
    bus.id_we = id.we; bus.id_load = id.ld; bus.ex_br_taken = br; bus.dmem_wait = dw;
    #1;
    if (!rn) begin
      for (int i = 0; i < 8; i++) ring[i] = '0;
      cnt = 0; cnt2 = 0; held = 3'b000;
    end
    x = at_age(0);
    hz = 1'b0;
    if (id.v) begin
      if (FWD != 0) begin
        hz = x.ld && (writes(x, id.rs1, id.e1) || writes(x, id.rs2, id.e2));
      end else begin
        for (int a = 0; a < 3; a++)
          if (writes(at_age(a), id.rs1, id.e1) || writes(at_age(a), id.rs2, id.e2)) hz = 1'b1;
      end
    end
    ctl = {!br && hz, br || hz, br};
    e_fa = 0; e_fb = 0;
    if (!rn) begin
      ctl = 3'b000; e_frz = 0;
    end else if (dw) begin
      ctl = held; e_frz = 1;
    end else begin
      e_frz = 0;
      if (FWD != 0 && x.v) begin
        e_fa = fwd_sel(x.rs1, x.e1);
        e_fb = fwd_sel(x.rs2, x.e2);
      end
    end
    e_stall = int'(ctl[2]); e_bub = int'(ctl[1]); e_fl = int'(ctl[0]);
    chk("stall_if", int'(bus.stall_if_c), e_stall);
    chk("bubble_ex", int'(bus.bubble_ex_c), e_bub);
    chk("flush_id", int'(bus.flush_id_c), e_fl);
    chk("freeze", int'(bus.freeze_c), e_frz);
    chk("fwd_a", int'(bus.fwd_a_c), e_fa);
    chk("fwd_b", int'(bus.fwd_b_c), e_fb);
    chk("haz_cnt", int'(bus.haz_cnt), cnt);
    chk("haz_cnt_cw2", int'(bus2.haz_cnt), cnt2);
    if (rn && !dw) begin
      held = ctl;
      if (ctl[2]) begin
        if (cnt < 65535) cnt++;
        if (cnt2 < 3) cnt2++;
      end
      t++;
      ring[t & 7] = (id.v && !hz && !br) ? id : idle_op;
    end
  endtask

  // Hold an op in ID until it issues; bounded so a stuck stall cannot hang the run
  task automatic issue(input op_t id, output int stalls);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      step(id, 1'b0, 1'b0, 1'b1);
      if (!bus.stall_if_c) return;
      stalls++;
    end
    chk("issue_timeout", stalls, -1);
  endtask

  task automatic do_reset();
    step(idle_op, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int s;
    op_t o;
    bit br, dw, rn;
    for (int i = 0; i < 8; i++) ring[i] = '0;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_en = 0; bus.id_rs2_en = 0;
    bus.id_rd = 0; bus.id_we = 0; bus.id_load = 0; bus.ex_br_taken = 0; bus.dmem_wait = 0;
    do_reset();
    do_reset();

    // T1: reset while a hazard stall and a memory wait are in progress
    step(mk(3, 1, 2, 1'b1), 1'b0, 1'b0, 1'b1);
    step(mk(5, 3, 4, 1'b0), 1'b0, 1'b0, 1'b1);
    chk("t1_pre_stall", int'(bus.stall_if_c), 1);
    step(mk(5, 3, 4, 1'b0), 1'b0, 1'b1, 1'b0);
    chk("t1_rst_stall", int'(bus.stall_if_c), 0);
    chk("t1_rst_freeze", int'(bus.freeze_c), 0);
    chk("t1_rst_cnt", int'(bus.haz_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      step(mk(10 + k, 20, 21, 1'b0), 1'b0, 1'b0, 1'b1);
      chk("t1_indep_stall", int'(bus.stall_if_c), 0);
    end

    // T2: back-to-back RAW on r3
    do_reset();
    step(mk(3, 1, 2, 1'b0), 1'b0, 1'b0, 1'b1);
    issue(mk(5, 3, 4, 1'b0), s);
    chk("t2_stall_len", s, (FWD != 0) ? 0 : 3);
    chk("t2_haz_cnt", int'(bus.haz_cnt), (FWD != 0) ? 0 : 3);

    // T3: forwarding distance 1 then 2
    do_reset();
    step(mk(3, 1, 2, 1'b0), 1'b0, 1'b0, 1'b1);
    issue(mk(6, 3, 1, 1'b0), s);
    step(idle_op, 1'b0, 1'b0, 1'b1);
    chk("t3_fwd_a_mem", int'(bus.fwd_a_c), (FWD != 0) ? 1 : 0);
    do_reset();
    step(mk(3, 1, 2, 1'b0), 1'b0, 1'b0, 1'b1);
    step(mk(9, 10, 11, 1'b0), 1'b0, 1'b0, 1'b1);
    issue(mk(6, 3, 1, 1'b0), s);
    step(idle_op, 1'b0, 1'b0, 1'b1);
    chk("t3_fwd_a_wb", int'(bus.fwd_a_c), (FWD != 0) ? 2 : 0);

    // T4: load-use; after the bubble the load sits in WB when the consumer reaches EX
    do_reset();
    step(mk(7, 1, 2, 1'b1), 1'b0, 1'b0, 1'b1);
    issue(mk(8, 7, 7, 1'b0), s);
    chk("t4_stall_len", s, (FWD != 0) ? 1 : 3);
    step(idle_op, 1'b0, 1'b0, 1'b1);
    chk("t4_fwd_a", int'(bus.fwd_a_c), (FWD != 0) ? 2 : 0);
    chk("t4_fwd_b", int'(bus.fwd_b_c), (FWD != 0) ? 2 : 0);

    // T5: taken branch overrides a pending hazard
    do_reset();
    step(mk(3, 1, 2, 1'b1), 1'b0, 1'b0, 1'b1);
    step(mk(5, 3, 4, 1'b0), 1'b1, 1'b0, 1'b1);
    chk("t5_flush", int'(bus.flush_id_c), 1);
    chk("t5_bubble", int'(bus.bubble_ex_c), 1);
    chk("t5_stall", int'(bus.stall_if_c), 0);
    chk("t5_cnt", int'(bus.haz_cnt), 0);

    // T6: freeze during a stall, then the stall resumes with its remaining length
    do_reset();
    step(mk(3, 1, 2, 1'b1), 1'b0, 1'b0, 1'b1);
    step(mk(5, 3, 4, 1'b0), 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(mk(5, 3, 4, 1'b0), 1'b0, 1'b1, 1'b1);
    chk("t6_freeze", int'(bus.freeze_c), 1);
    chk("t6_held_stall", int'(bus.stall_if_c), 1);
    chk("t6_held_cnt", int'(bus.haz_cnt), 1);
    issue(mk(5, 3, 4, 1'b0), s);
    chk("t6_remaining", s, (FWD != 0) ? 0 : 2);
    chk("t6_total_cnt", int'(bus.haz_cnt), (FWD != 0) ? 1 : 3);

    // Counter saturation on the CW=2 instance
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(mk(7, 1, 2, 1'b1), 1'b0, 1'b0, 1'b1);
      issue(mk(8, 7, 7, 1'b0), s);
    end
    chk("sat_cnt_cw16", int'(bus.haz_cnt), (FWD != 0) ? 4 : 12);
    chk("sat_cnt_cw2", int'(bus2.haz_cnt), 3);

    // Randomized traffic over a small register set to provoke dependencies
    for (int i = 0; i < 3000; i++) begin
      o = '0;
      o.v   = ($urandom_range(0, 9) < 8);
      o.we  = ($urandom_range(0, 4) != 0);
      o.ld  = ($urandom_range(0, 3) == 0);
      o.e1  = ($urandom_range(0, 5) != 0);
      o.e2  = ($urandom_range(0, 5) != 0);
      o.rd  = 5'($urandom_range(0, 7));
      o.rs1 = 5'($urandom_range(0, 7));
      o.rs2 = 5'($urandom_range(0, 7));
      br = ($urandom_range(0, 9) == 0);
      dw = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 199) != 0);
      step(o, br, dw, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
